// File: rtl/ysyx_23060201_gpr_wb_sched.sv
// GPR write-back scheduler: round-robin between ALU (wb0) and LSU (wb1), plus RAW/WAW scoreboard.
// Write port registered (1 cycle after grant); ungranted requester is held off via wbN_ready, issue held off via issue_ready.
module ysyx_23060201_gpr_wb_sched #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [1:0]                issue_rs_en,
    input  logic [ADDR_WIDTH-1:0]     issue_rs1,
    input  logic [ADDR_WIDTH-1:0]     issue_rs2,
    input  logic                      issue_rd_en,
    input  logic [ADDR_WIDTH-1:0]     issue_rd,
    input  logic                      wb0_valid,
    output logic                      wb0_ready,
    input  logic [ADDR_WIDTH-1:0]     wb0_rd,
    input  logic [DATA_WIDTH-1:0]     wb0_data,
    input  logic                      wb1_valid,
    output logic                      wb1_ready,
    input  logic [ADDR_WIDTH-1:0]     wb1_rd,
    input  logic [DATA_WIDTH-1:0]     wb1_data,
    output logic                      gpr_wen,
    output logic [ADDR_WIDTH-1:0]     gpr_waddr,
    output logic [DATA_WIDTH-1:0]     gpr_wdata,
    output logic [(1<<ADDR_WIDTH)-1:0] busy_vec,
    output logic                      sb_err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy_q, busy_d;
    logic                  rr_q, rr_d;      // 0: wb0 wins a tie, 1: wb1 wins a tie
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;

    logic                  stall;
    logic                  alloc;
    logic                  gnt0, gnt1, any_gnt;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        stall = (issue_rs_en[0] & busy_q[issue_rs1])
              | (issue_rs_en[1] & busy_q[issue_rs2])
              | (issue_rd_en    & busy_q[issue_rd]);
        issue_ready = issue_valid & ~stall;
        alloc       = issue_ready & issue_rd_en & (issue_rd != '0);
    end

    always_comb begin
        gnt0     = wb0_valid & (~wb1_valid | ~rr_q);
        gnt1     = wb1_valid & (~wb0_valid |  rr_q);
        any_gnt  = gnt0 | gnt1;
        sel_rd   = gnt1 ? wb1_rd   : wb0_rd;
        sel_data = gnt1 ? wb1_data : wb0_data;
    end

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;

    always_comb begin
        busy_d  = busy_q;
        rr_d    = rr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        // Release is driven by the registered write so the GPR already holds the value when busy drops.
        if (wen_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (alloc) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
        if (any_gnt) begin
            wen_d   = (sel_rd != '0);
            waddr_d = sel_rd;
            wdata_d = sel_data;
            if ((sel_rd != '0) && !busy_q[sel_rd]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q  <= '0;
            rr_q    <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            rr_q    <= rr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign gpr_wen   = wen_q;
    assign gpr_waddr = waddr_q;
    assign gpr_wdata = wdata_q;
    assign busy_vec  = busy_q;
    assign sb_err    = err_q;

endmodule

// File: tb/tb_ysyx_23060201_gpr_wb_sched.sv
// Bench for the GPR write-back scheduler: hazard table, directed corner sequences, randomized run against a model.
module tb_ysyx_23060201_gpr_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [1:0]  issue_rs_en;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rd_en;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [31:0] busy_vec;
    logic        sb_err;

    ysyx_23060201_gpr_wb_sched #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs_en(issue_rs_en), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .busy_vec(busy_vec), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] rs_en;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rd_en;
        logic [4:0] rd;
        logic       exp_rdy;
    } hz_vec_t;

    hz_vec_t tbl[10];
    int n_cmp = 0;
    int n_fail = 0;

    // Reference state: what the spec says the scheduler holds after each posedge.
    logic [31:0] m_busy;
    logic        m_fav1;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_err;
    logic        p_v[2];
    logic [4:0]  p_rd[2];
    logic [31:0] p_dat[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rs_en = 2'b00; issue_rs1 = '0; issue_rs2 = '0;
        issue_rd_en = 1'b0; issue_rd = '0;
        wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic issue_rd_only(input logic [4:0] rd);
        idle();
        issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = rd;
        step();
        idle();
    endtask

    function automatic logic [4:0] pick_rd();
        int q[$];
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
        for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
        if (q.size() == 0) return 5'($urandom_range(0, 7));
        return 5'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    initial begin
        logic stall_m, rdy_m, g0, g1, have_g;
        logic [4:0]  g_rd;
        logic [31:0] nb;

        tbl[0] = '{1'b0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0};
        tbl[1] = '{1'b1, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0};
        tbl[2] = '{1'b1, 2'b00, 5'd5, 5'd9, 1'b0, 5'd0, 1'b1};
        tbl[3] = '{1'b1, 2'b10, 5'd1, 5'd9, 1'b0, 5'd0, 1'b0};
        tbl[4] = '{1'b1, 2'b01, 5'd9, 5'd5, 1'b0, 5'd0, 1'b0};
        tbl[5] = '{1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0};
        tbl[6] = '{1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1};
        tbl[7] = '{1'b1, 2'b11, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1};
        tbl[8] = '{1'b1, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1};
        tbl[9] = '{1'b1, 2'b10, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0};

        // Reset then idle, with an issue presented during reset.
        idle();
        rst = 1'b0;
        step();
        issue_valid = 1'b1; issue_rs_en = 2'b11; issue_rs1 = 5'd1; issue_rs2 = 5'd2;
        step();
        @(negedge clk);
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_wen", gpr_wen, 0);
        chk("rst_waddr", gpr_waddr, 0);
        chk("rst_wdata", gpr_wdata, 0);
        chk("rst_err", sb_err, 0);
        chk("rst_ready_hi", issue_ready, 1);
        issue_valid = 1'b0;
        #1 chk("rst_ready_lo", issue_ready, 0);
        rst = 1'b1;
        step();

        // RAW stall and release timing.
        issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd5;
        @(negedge clk) chk("raw_alloc_rdy", issue_ready, 1);
        step();
        idle();
        issue_valid = 1'b1; issue_rs_en = 2'b01; issue_rs1 = 5'd5;
        @(negedge clk);
        chk("raw_busy5", busy_vec, 32'h20);
        chk("raw_stall", issue_ready, 0);
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
        #1 chk("raw_wb0_rdy", wb0_ready, 1);
        step();
        wb0_valid = 1'b0;
        @(negedge clk);
        chk("raw_wen", gpr_wen, 1);
        chk("raw_waddr", gpr_waddr, 5);
        chk("raw_wdata", gpr_wdata, 32'hDEADBEEF);
        chk("raw_still_busy", busy_vec, 32'h20);
        chk("raw_still_stall", issue_ready, 0);
        step();
        @(negedge clk);
        chk("raw_release", busy_vec, 32'h0);
        chk("raw_dep_issue", issue_ready, 1);
        chk("raw_wen_off", gpr_wen, 0);
        chk("raw_waddr_hold", gpr_waddr, 5);
        step();

        // Hazard table against busy = {x5, x9}.
        issue_rd_only(5'd5);
        issue_rd_only(5'd9);
        for (int i = 0; i < 10; i++) begin
            issue_valid = tbl[i].v; issue_rs_en = tbl[i].rs_en;
            issue_rs1 = tbl[i].rs1; issue_rs2 = tbl[i].rs2;
            issue_rd_en = tbl[i].rd_en; issue_rd = tbl[i].rd;
            @(negedge clk);
            chk($sformatf("hz_tbl[%0d]", i), issue_ready, tbl[i].exp_rdy);
            idle();
            step();
        end
        chk("hz_busy", busy_vec, 32'h220);
        do_reset();

        // Contention: continuous requests alternate starting with wb0.
        issue_rd_only(5'd3);
        issue_rd_only(5'd4);
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'hA;
        wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'hB;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) chk($sformatf("rr_waddr[%0d]", i - 1), gpr_waddr, (i % 2 == 1) ? 5'd3 : 5'd4);
            chk($sformatf("rr_gnt0[%0d]", i), wb0_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_gnt1[%0d]", i), wb1_ready, (i % 2 == 0) ? 0 : 1);
            step();
        end
        idle();
        @(negedge clk) chk("rr_waddr[5]", gpr_waddr, 4);
        do_reset();

        // x0 write-back: consumed, no write, no error.
        issue_rd_only(5'd6);
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h1234;
        @(negedge clk);
        chk("x0_wb1_rdy", wb1_ready, 1);
        chk("x0_wb0_rdy", wb0_ready, 0);
        step();
        wb1_valid = 1'b0;
        @(negedge clk);
        chk("x0_wen", gpr_wen, 0);
        chk("x0_busy", busy_vec, 32'h40);
        chk("x0_err", sb_err, 0);
        chk("x0_wdata", gpr_wdata, 32'h1234);
        step();

        // Spurious write-back sets the sticky error but still writes.
        wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77;
        @(negedge clk) chk("spur_rdy", wb0_ready, 1);
        step();
        wb0_valid = 1'b0;
        @(negedge clk);
        chk("spur_wen", gpr_wen, 1);
        chk("spur_waddr", gpr_waddr, 7);
        chk("spur_wdata", gpr_wdata, 32'h77);
        chk("spur_err", sb_err, 1);
        step(); step(); step();
        @(negedge clk);
        chk("spur_err_sticky", sb_err, 1);
        chk("spur_busy", busy_vec, 32'h40);
        do_reset();
        @(negedge clk) chk("spur_err_cleared", sb_err, 0);

        // Reset while a write is in flight and the pointer favours wb1.
        issue_rd_only(5'd9);
        issue_rd_only(5'd10);
        wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h9;
        step();
        wb1_valid = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd10; wb0_data = 32'h10;
        step();
        wb0_valid = 1'b0;
        @(negedge clk);
        chk("mid_wen", gpr_wen, 1);
        chk("mid_busy", busy_vec, 32'h400);
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy_vec, 32'h0);
        chk("mid_rst_wen", gpr_wen, 0);
        chk("mid_rst_waddr", gpr_waddr, 0);
        wb0_valid = 1'b1; wb1_valid = 1'b1; wb0_rd = '0; wb1_rd = '0;
        #1;
        chk("mid_rst_ptr0", wb0_ready, 1);
        chk("mid_rst_ptr1", wb1_ready, 0);
        idle();
        step();

        // Randomized run against the reference model.
        do_reset();
        m_busy = '0; m_fav1 = 1'b0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
        for (int r = 0; r < 2; r++) begin p_v[r] = 1'b0; p_rd[r] = '0; p_dat[r] = '0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_v[r] && $urandom_range(0, 2) == 0) begin
                    p_v[r] = 1'b1; p_rd[r] = pick_rd(); p_dat[r] = $urandom;
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rs_en = 2'($urandom_range(0, 3));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd_en = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            wb0_valid = p_v[0]; wb0_rd = p_rd[0]; wb0_data = p_dat[0];
            wb1_valid = p_v[1]; wb1_rd = p_rd[1]; wb1_data = p_dat[1];
            @(negedge clk);
            stall_m = (issue_rs_en[0] && m_busy[issue_rs1]) || (issue_rs_en[1] && m_busy[issue_rs2])
                   || (issue_rd_en && m_busy[issue_rd]);
            rdy_m = issue_valid && !stall_m;
            if (p_v[0] && p_v[1]) begin
                g0 = !m_fav1; g1 = m_fav1;
            end else begin
                g0 = p_v[0]; g1 = p_v[1];
            end
            chk("rnd_issue_ready", issue_ready, rdy_m);
            chk("rnd_wb0_ready", wb0_ready, g0);
            chk("rnd_wb1_ready", wb1_ready, g1);
            chk("rnd_gpr_wen", gpr_wen, m_wen);
            chk("rnd_gpr_waddr", gpr_waddr, m_waddr);
            chk("rnd_gpr_wdata", gpr_wdata, m_wdata);
            chk("rnd_busy_vec", busy_vec, m_busy);
            chk("rnd_sb_err", sb_err, m_err);
            nb = m_busy;
            if (m_wen) nb[m_waddr] = 1'b0;
            if (rdy_m && issue_rd_en && issue_rd != 0) nb[issue_rd] = 1'b1;
            have_g = g0 || g1;
            g_rd = g1 ? p_rd[1] : p_rd[0];
            if (have_g) begin
                if (g_rd != 0 && !m_busy[g_rd]) m_err = 1'b1;
                m_wen = (g_rd != 0);
                m_waddr = g_rd;
                m_wdata = g1 ? p_dat[1] : p_dat[0];
                m_fav1 = g0;
                if (g0) p_v[0] = 1'b0;
                if (g1) p_v[1] = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
            m_busy = nb;
            step();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
